// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state codes,
// supported opcodes, datapath mux encodings and the control word layout.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic is_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_J, OP_JAL: ok = 1'b1;
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when leaving state s this cycle completes an instruction.
  function automatic logic retires(input state_t s, input logic mem_ready);
    logic r;
    case (s)
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH,
      S_JUMP, S_JAL, S_JR: r = 1'b1;
      S_MEM_WRITE:         r = mem_ready;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode: a Moore map from the current state,
// with the only exceptions being FETCH (gated by mem_ready) and BRANCH
// (which branch flavour comes from the opcode).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  // Drive the datapath strobes and mux selects for the current state.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dest   = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = ALUB_REG;
        ctrl.alu_op      = ALUOP_SUB;
        ctrl.pc_source   = PCSRC_ALUOUT;
        ctrl.pc_write_eq = (opcode == OP_BEQ);
        ctrl.pc_write_ne = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_REG;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state sequencing,
// retired-instruction counter and sticky illegal-opcode flag. Control
// outputs are forced low while reset is held so an abandoned instruction
// cannot issue a write in the reset cycle.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dest,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               jal,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired,
  output logic               illegal_seen
);

  state_t             state_r;
  state_t             next_state_s;
  ctrl_t              ctrl_s;
  ctrl_t              ctrl_gated_s;
  logic [COUNT_W-1:0] retired_r;
  logic               illegal_r;

  mc_ctrl_decode u_decode (
    .state     (state_r),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  // Sequence to the next state from the current state, opcode and handshake.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FUNCT_JR) next_state_s = S_JR;
            else                   next_state_s = S_EXECUTE;
          end
          OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
          OP_ADDI:        next_state_s = S_ADDI_EXEC;
          OP_J:           next_state_s = S_JUMP;
          OP_JAL:         next_state_s = S_JAL;
          default:        next_state_s = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_SW)      next_state_s = S_MEM_WRITE;
        else if (opcode == OP_LW) next_state_s = S_MEM_READ;
        else                      next_state_s = S_FETCH;
      end
      S_MEM_READ: begin
        if (mem_ready) next_state_s = S_MEM_WB;
        else           next_state_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (mem_ready) next_state_s = S_FETCH;
        else           next_state_s = S_MEM_WRITE;
      end
      S_EXECUTE:   next_state_s = S_R_WB;
      S_ADDI_EXEC: next_state_s = S_ADDI_WB;
      default:     next_state_s = S_FETCH;
    endcase
  end

  // State register; reset returns to instruction fetch.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= next_state_s;
  end

  // Count completed instructions; wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk) begin
    if (reset)                          retired_r <= '0;
    else if (retires(state_r, mem_ready)) retired_r <= retired_r + COUNT_W'(1);
    else                                retired_r <= retired_r;
  end

  // Remember that an unsupported opcode reached decode until the next reset.
  always_ff @(posedge clk) begin
    if (reset)                                           illegal_r <= 1'b0;
    else if (state_r == S_DECODE && !is_supported(opcode)) illegal_r <= 1'b1;
    else                                                 illegal_r <= illegal_r;
  end

  // Suppress every control strobe while reset is asserted.
  always_comb begin
    ctrl_gated_s = ctrl_s;
    if (reset) ctrl_gated_s = '0;
    else       ctrl_gated_s = ctrl_s;
  end

  assign pc_write     = ctrl_gated_s.pc_write;
  assign pc_write_eq  = ctrl_gated_s.pc_write_eq;
  assign pc_write_ne  = ctrl_gated_s.pc_write_ne;
  assign i_or_d       = ctrl_gated_s.i_or_d;
  assign mem_read     = ctrl_gated_s.mem_read;
  assign mem_write    = ctrl_gated_s.mem_write;
  assign ir_write     = ctrl_gated_s.ir_write;
  assign reg_dest     = ctrl_gated_s.reg_dest;
  assign mem_to_reg   = ctrl_gated_s.mem_to_reg;
  assign reg_write    = ctrl_gated_s.reg_write;
  assign jal          = ctrl_gated_s.jal;
  assign alu_src_a    = ctrl_gated_s.alu_src_a;
  assign alu_src_b    = ctrl_gated_s.alu_src_b;
  assign alu_op       = ctrl_gated_s.alu_op;
  assign pc_source    = ctrl_gated_s.pc_source;
  assign state        = reset ? 4'd0 : state_r;
  assign retired      = retired_r;
  assign illegal_seen = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each directed instruction is expanded into
// the list of states it must visit (with requested memory stalls), and each
// cycle the DUT is compared against the per-state output table and an
// instruction-level retired/illegal model. A second instance with a 4-bit
// counter checks wrap-around.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;

  logic        pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write;
  logic        ir_write, reg_dest, mem_to_reg, reg_write, jal, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        illegal_seen;

  logic        d4_pc_write, d4_pc_write_eq, d4_pc_write_ne, d4_i_or_d, d4_mem_read;
  logic        d4_mem_write, d4_ir_write, d4_reg_dest, d4_mem_to_reg, d4_reg_write;
  logic        d4_jal, d4_alu_src_a, d4_illegal_seen;
  logic [1:0]  d4_alu_src_b, d4_alu_op, d4_pc_source;
  logic [3:0]  d4_state;
  logic [3:0]  d4_retired;

  logic [17:0] act_ctrl;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_retired;
  logic        exp_illegal;
  logic [5:0]  cur_op;
  logic [5:0]  cur_funct;

  multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dest(reg_dest), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .retired(retired), .illegal_seen(illegal_seen)
  );

  multicycle_control #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(d4_pc_write), .pc_write_eq(d4_pc_write_eq), .pc_write_ne(d4_pc_write_ne),
    .i_or_d(d4_i_or_d), .mem_read(d4_mem_read), .mem_write(d4_mem_write),
    .ir_write(d4_ir_write), .reg_dest(d4_reg_dest), .mem_to_reg(d4_mem_to_reg),
    .reg_write(d4_reg_write), .jal(d4_jal), .alu_src_a(d4_alu_src_a),
    .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op), .pc_source(d4_pc_source),
    .state(d4_state), .retired(d4_retired), .illegal_seen(d4_illegal_seen)
  );

  always #5 clk = ~clk;

  assign act_ctrl = {pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write,
                     ir_write, reg_dest, mem_to_reg, reg_write, jal, alu_src_a,
                     alu_src_b, alu_op, pc_source};

  // Output table straight from the state descriptions.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
    logic pcw, eq, ne, iod, mr, mw, irw, rd, m2r, rw, jl, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, eq, ne, iod, mr, mw, irw, rd, m2r, rw, jl, asa} = 12'b0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01;
                eq = (op == 6'h04); ne = (op == 6'h05); end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: begin rw = 1'b1; end
      12: begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; jl = 1'b1; end
      13: begin pcw = 1'b1; pcs = 2'b11; end
      default: ;
    endcase
    return {pcw, eq, ne, iod, mr, mw, irw, rd, m2r, rw, jl, asa, asb, aop, pcs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock cycle in which the DUT must be in state st.
  task automatic cycle(input int st, input logic rdy);
    @(negedge clk);
    reset = 1'b0; opcode = cur_op; funct = cur_funct; mem_ready = rdy;
    #1;
    check("state", 32'(state), 32'(st));
    check("state_w4", 32'(d4_state), 32'(st));
    check("ctrl", 32'(act_ctrl), 32'(exp_ctrl(st, cur_op, rdy)));
    check("retired", retired, exp_retired);
    check("retired_w4", 32'(d4_retired), 32'(exp_retired[3:0]));
    check("illegal_seen", 32'(illegal_seen), 32'(exp_illegal));
  endtask

  // One reset cycle: all control outputs must be low.
  task automatic reset_cycle();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    check("reset_ctrl", 32'(act_ctrl), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    exp_retired = 32'd0;
    exp_illegal = 1'b0;
  endtask

  // Move just past the next rising edge for hand-computed spot checks.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction through every state it must visit.
  task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait);
    logic legal;
    cur_op    = instr[31:26];
    cur_funct = instr[5:0];
    case (cur_op)
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    for (int i = 0; i < fwait; i++) cycle(0, 1'b0);
    cycle(0, 1'b1);
    cycle(1, 1'b1);
    case (cur_op)
      6'h00: begin
        if (cur_funct == 6'h08) cycle(13, 1'b1);
        else begin cycle(6, 1'b1); cycle(7, 1'b1); end
      end
      6'h23: begin
        cycle(2, 1'b1);
        for (int i = 0; i < mwait; i++) cycle(3, 1'b0);
        cycle(3, 1'b1);
        cycle(4, 1'b1);
      end
      6'h2B: begin
        cycle(2, 1'b1);
        for (int i = 0; i < mwait; i++) cycle(5, 1'b0);
        cycle(5, 1'b1);
      end
      6'h04, 6'h05: cycle(8, 1'b1);
      6'h08: begin cycle(10, 1'b1); cycle(11, 1'b1); end
      6'h02: cycle(9, 1'b1);
      6'h03: cycle(12, 1'b1);
      default: ;
    endcase
    if (legal) exp_retired = exp_retired + 32'd1;
    else       exp_illegal = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    cur_op = 6'h00; cur_funct = 6'h00;
    exp_retired = 32'd0; exp_illegal = 1'b0;

    reset_cycle();
    reset_cycle();
    after_edge();
    check("post_reset_state", 32'(state), 32'd0);
    check("post_reset_retired", retired, 32'd0);

    run_instr(32'h8C080004, 0, 0);          // lw, no stalls
    after_edge();
    check("lw_retired", retired, 32'd1);
    run_instr(32'h8C080004, 3, 2);          // lw with fetch and memory stalls
    run_instr(32'h10000003, 0, 0);          // beq
    run_instr(32'h14000003, 0, 0);          // bne
    after_edge();
    check("branch_retired", retired, 32'd4);
    run_instr(32'h0C000010, 0, 0);          // jal
    run_instr(32'h03E00008, 0, 0);          // jr $31
    after_edge();
    check("jal_jr_retired", retired, 32'd6);
    run_instr(32'h20080005, 1, 0);          // addi
    run_instr(32'h08000000, 0, 0);          // j
    run_instr(32'h01095020, 0, 0);          // add (R-type)
    run_instr(32'hAC080004, 0, 2);          // sw with memory stalls
    run_instr(32'hFC000000, 0, 0);          // opcode 0x3F, unsupported
    after_edge();
    check("illegal_flag", 32'(illegal_seen), 32'd1);
    check("illegal_retired", retired, 32'd10);
    run_instr(32'h8C080004, 0, 0);          // flag must stay set
    after_edge();
    check("illegal_sticky", 32'(illegal_seen), 32'd1);

    // sw stalled in MEM_WRITE, then reset mid-instruction
    cur_op = 6'h2B; cur_funct = 6'h04;
    cycle(0, 1'b1);
    cycle(1, 1'b1);
    cycle(2, 1'b1);
    cycle(5, 1'b0);
    reset_cycle();
    after_edge();
    check("abort_state", 32'(state), 32'd0);
    check("abort_retired", retired, 32'd0);
    check("abort_illegal", 32'(illegal_seen), 32'd0);

    // 16 back-to-back R-types: the 4-bit counter wraps to 0
    for (int n = 0; n < 16; n++) run_instr(32'h01095020, 0, 0);
    after_edge();
    check("wrap_w4", 32'(d4_retired), 32'd0);
    check("wrap_w32", retired, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle variant of the MIPS datapath.
- Shares one memory port between instruction fetch and data access, and reuses one ALU for PC+4, branch target and execute.
- Replaces the single-cycle combinational control unit. Adds a memory ready handshake, a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_eq  out  1  PC load if ALU zero = 1 (beq).
- pc_write_ne  out  1  PC load if ALU zero = 0 (bne).
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load the instruction register.
- reg_dest  out  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write enable.
- jal  out  1  force write register to 31 and write data to PC (already PC+4).
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address, 11 = register A.
- state  out  4  current state code, for debug.
- retired  out  COUNT_W  count of completed instructions.
- illegal_seen  out  1  sticky; set when an unsupported opcode is decoded.

Behaviour:
- Reset:
  - While reset = 1, every control output is 0.
  - At the next edge: state = FETCH, retired = 0, illegal_seen = 0.
  - Reset mid-instruction abandons that instruction; no write strobes are issued in the reset cycle.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, JAL=12, JR=13.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 with funct 0x08 -> JR.
    - 0x00 with any other funct -> EXECUTE.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x04 or 0x05 -> BRANCH.
    - 0x08 -> ADDI_EXEC.
    - 0x02 -> JUMP.
    - 0x03 -> JAL.
    - Any other opcode -> FETCH, set illegal_seen; retired is not incremented.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dest=0.
  - Next: FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - Waits for mem_ready, then goes to FETCH.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next: R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dest=1.
  - Next: FETCH.
- ADDI_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write=1, reg_dest=0.
  - Next: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write_eq=1 if opcode=0x04; pc_write_ne=1 if opcode=0x05.
  - Next: FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - Next: FETCH.
- JAL:
  - Outputs: pc_write=1, pc_source=10, reg_write=1, jal=1.
  - Next: FETCH.
- JR:
  - Outputs: pc_write=1, pc_source=11.
  - Next: FETCH.
- Retired counter:
  - retired += 1 on every transition into FETCH from MEM_WB, MEM_WRITE (with mem_ready), R_WB, ADDI_WB, BRANCH, JUMP, JAL or JR.
  - Wraps modulo 2^COUNT_W.
- Control outputs are combinational decodes of state, opcode and mem_ready only; no other input affects them.
- The FSM never deadlocks except in a mem_ready wait state.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state encoding;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL) and FUNCT_JR;
  - alu_src_b, alu_op and pc_source encodings.
- Sub-module mc_ctrl_decode: purely combinational mapping from state, opcode and mem_ready to the control word.
- multicycle_control holds the state register, next-state logic, counter and sticky flag.

Test Plan:
- lw (instr 0x8C080004), mem_ready tied 1 -> states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1. retired 0 -> 1.
- mem_ready held 0 for 3 cycles in FETCH -> state stays 0 for 4 cycles. pc_write and ir_write are 0 until the cycle mem_ready=1, then 1 for exactly one cycle.
- beq (0x10000003), then bne (0x14000003) -> 3 cycles each. pc_write_eq=1 only in beq's BRANCH; pc_write_ne=1 only in bne's BRANCH. alu_op=01 in both. retired +2.
- jal (0x0C000010), then jr $31 (0x03E00008) -> JAL outputs pc_source=10, reg_write=1, jal=1. JR outputs pc_source=11, pc_write=1. retired +2.
- Opcode 0x3F -> FETCH, DECODE, FETCH. illegal_seen=1 and stays 1. retired unchanged. No write strobes asserted.
- sw with mem_ready=0, reset asserted in MEM_WRITE -> all outputs 0 that cycle. Next state FETCH, retired=0.
- COUNT_W=4, 16 back-to-back R-type instructions -> retired reads 0 after the 16th.
